// File: rtl/axi_sram_slv.sv
// AXI4 responder backed by a 64-bit SRAM array; independent read/write FSMs,
// INCR bursts, byte strobes, ID echo, SLVERR for beats outside the window.
`timescale 1ns/1ps
module axi_sram_slv #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH = 4,
    parameter int MEM_DEPTH = 1024,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXI_ID_WIDTH-1:0]   aw_id,
    input  logic [AXI_ADDR_WIDTH-1:0] aw_addr,
    input  logic [7:0]                aw_len,
    input  logic                      aw_valid,
    output logic                      aw_ready,
    input  logic [63:0]               w_data,
    input  logic [7:0]                w_strb,
    input  logic                      w_last,
    input  logic                      w_valid,
    output logic                      w_ready,
    output logic [AXI_ID_WIDTH-1:0]   b_id,
    output logic [1:0]                b_resp,
    output logic                      b_valid,
    input  logic                      b_ready,
    input  logic [AXI_ID_WIDTH-1:0]   ar_id,
    input  logic [AXI_ADDR_WIDTH-1:0] ar_addr,
    input  logic [7:0]                ar_len,
    input  logic                      ar_valid,
    output logic                      ar_ready,
    output logic [AXI_ID_WIDTH-1:0]   r_id,
    output logic [63:0]               r_data,
    output logic [1:0]                r_resp,
    output logic                      r_last,
    output logic                      r_valid,
    input  logic                      r_ready
);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    // Window bounds kept in word units with one spare bit so the top never wraps.
    localparam logic [AXI_ADDR_WIDTH:0] LO_W = {1'b0, BASE_ADDR} >> 3;
    localparam logic [AXI_ADDR_WIDTH:0] HI_W = LO_W + (AXI_ADDR_WIDTH+1)'(MEM_DEPTH);

    function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] a);
        logic [AXI_ADDR_WIDTH:0] wa;
        wa = {1'b0, a} >> 3;
        return (wa >= LO_W) && (wa < HI_W);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] a);
        logic [AXI_ADDR_WIDTH-1:0] off;
        off = (a - BASE_ADDR) >> 3;
        return IDX_W'(off);
    endfunction

    logic [63:0] mem [MEM_DEPTH];

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    w_state_t w_state, w_state_nx;
    r_state_t r_state, r_state_nx;

    logic [AXI_ADDR_WIDTH-1:0] w_addr, r_addr;
    logic [7:0] w_len, w_beat, r_len, r_beat;
    logic w_err;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic w_beat_last, w_beat_ok, w_beat_err, r_beat_last, r_beat_ok;

    // Handshakes are qualified by rst so the cycle that enters reset commits nothing.
    assign aw_hs = aw_valid & aw_ready & rst;
    assign w_hs  = w_valid & w_ready & rst;
    assign b_hs  = b_valid & b_ready & rst;
    assign ar_hs = ar_valid & ar_ready & rst;
    assign r_hs  = r_valid & r_ready & rst;

    assign w_beat_last = (w_beat == w_len);
    assign w_beat_ok   = in_range(w_addr);
    assign w_beat_err  = !w_beat_ok || (w_last != w_beat_last);
    assign r_beat_last = (r_beat == r_len);
    assign r_beat_ok   = in_range(r_addr);

    always_comb begin
        w_state_nx = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_nx = W_DATA;
            W_DATA:  if (w_hs && w_beat_last) w_state_nx = W_RESP;
            W_RESP:  if (b_hs) w_state_nx = W_IDLE;
            default: w_state_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state  <= W_IDLE;
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
            b_valid  <= 1'b0;
            b_id     <= '0;
            b_resp   <= RESP_OKAY;
        end else begin
            w_state  <= w_state_nx;
            aw_ready <= (w_state_nx == W_IDLE);
            w_ready  <= (w_state_nx == W_DATA);
            b_valid  <= (w_state_nx == W_RESP);
            if (aw_hs) b_id <= aw_id;
            if (w_hs && w_beat_last) b_resp <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_ff @(posedge clk) begin
        if (aw_hs) begin
            w_addr <= aw_addr;
            w_len  <= aw_len;
            w_beat <= 8'd0;
            w_err  <= 1'b0;
        end else if (w_hs) begin
            w_addr <= w_addr + AXI_ADDR_WIDTH'(8);
            w_beat <= w_beat + 8'd1;
            if (w_beat_err) w_err <= 1'b1;
        end
    end

    // No reset on the array: contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_hs && w_beat_ok) begin
            for (int i = 0; i < 8; i++) begin
                if (w_strb[i]) mem[word_idx(w_addr)][8*i +: 8] <= w_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        r_state_nx = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_nx = R_FETCH;
            R_FETCH: r_state_nx = R_DATA;
            R_DATA:  if (r_hs) r_state_nx = r_beat_last ? R_IDLE : R_FETCH;
            default: r_state_nx = R_IDLE;
        endcase
    end

    // The fetch reads mem in the same edge a write may land, so it sees old data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= R_IDLE;
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_id     <= '0;
            r_resp   <= RESP_OKAY;
            r_data   <= 64'h0;
        end else begin
            r_state  <= r_state_nx;
            ar_ready <= (r_state_nx == R_IDLE);
            r_valid  <= (r_state_nx == R_DATA);
            if (ar_hs) r_id <= ar_id;
            if (r_state == R_FETCH) begin
                r_last <= r_beat_last;
                r_resp <= r_beat_ok ? RESP_OKAY : RESP_SLVERR;
                r_data <= r_beat_ok ? mem[word_idx(r_addr)] : 64'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ar_hs) begin
            r_addr <= ar_addr;
            r_len  <= ar_len;
            r_beat <= 8'd0;
        end else if (r_hs && !r_beat_last) begin
            r_addr <= r_addr + AXI_ADDR_WIDTH'(8);
            r_beat <= r_beat + 8'd1;
        end
    end

endmodule

// File: tb/tb_axi_sram_slv.sv
// Randomized bench for axi_sram_slv: a per-cycle compare process checks every output
// against a transaction-level model, plus literal expectations from directed cases.
`timescale 1ns/1ps
module tb_axi_sram_slv;
    localparam int DEPTH = 64;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int TMO = 200;

    logic clk, rst;
    logic [3:0] aw_id, b_id, ar_id, r_id;
    logic [31:0] aw_addr, ar_addr;
    logic [7:0] aw_len, ar_len, w_strb;
    logic aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
    logic ar_valid, ar_ready, r_last, r_valid, r_ready;
    logic [63:0] w_data, r_data;
    logic [1:0] b_resp, r_resp;

    axi_sram_slv #(.AXI_ADDR_WIDTH(32), .AXI_ID_WIDTH(4), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
        .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid),
        .r_ready(r_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tmo(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting %0d cycles (cycle %0d)", name, TMO, cyc);
    endtask

    // ---------------- reference model ----------------
    logic [63:0] mm [DEPTH];
    logic [7:0]  mk [DEPTH];

    function automatic bit inr(input logic [31:0] a);
        logic [63:0] x;
        x = {32'h0, a} & ~64'h7;
        return (x >= {32'h0, BASE}) && (x < {32'h0, BASE} + 64'(8 * DEPTH));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 3);
    endfunction

    initial begin
        bit e_aw_ready, e_w_ready, e_b_valid, e_ar_ready, e_r_valid, e_r_last;
        bit e_rstv, wfresh, rfresh, rfetch, werr;
        logic [3:0] e_b_id, e_r_id, wid;
        logic [1:0] e_b_resp, e_r_resp;
        logic [63:0] e_r_data, e_r_mask;
        logic [31:0] wa, ra;
        int wl, wb, rl, rb, idx;
        for (int i = 0; i < DEPTH; i++) mk[i] = 8'h00;
        e_aw_ready = 0; e_w_ready = 0; e_b_valid = 0; e_ar_ready = 0; e_r_valid = 0;
        e_r_last = 0; e_rstv = 1; wfresh = 1; rfresh = 1; rfetch = 0; werr = 0;
        e_b_id = 0; e_r_id = 0; wid = 0; e_b_resp = 0; e_r_resp = 0;
        e_r_data = 0; e_r_mask = 0; wa = 0; ra = 0; wl = 0; wb = 0; rl = 0; rb = 0;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                chk("aw_ready", aw_ready, e_aw_ready);
                chk("w_ready", w_ready, e_w_ready);
                chk("b_valid", b_valid, e_b_valid);
                chk("ar_ready", ar_ready, e_ar_ready);
                chk("r_valid", r_valid, e_r_valid);
                if (e_rstv) begin
                    chk("rst_b_id", b_id, 0);
                    chk("rst_b_resp", b_resp, 0);
                    chk("rst_r_id", r_id, 0);
                    chk("rst_r_resp", r_resp, 0);
                    chk("rst_r_data", r_data, 0);
                    chk("rst_r_last", r_last, 0);
                end
                if (e_b_valid) begin
                    chk("b_id", b_id, e_b_id);
                    chk("b_resp", b_resp, e_b_resp);
                end
                if (e_r_valid) begin
                    chk("r_id", r_id, e_r_id);
                    chk("r_resp", r_resp, e_r_resp);
                    chk("r_last", r_last, e_r_last);
                    chk("r_data", r_data & e_r_mask, e_r_data & e_r_mask);
                end
            end
            if (!rst) begin
                e_aw_ready = 0; e_w_ready = 0; e_b_valid = 0;
                e_ar_ready = 0; e_r_valid = 0; rfetch = 0;
                e_rstv = 1; wfresh = 1; rfresh = 1;
            end else begin
                e_rstv = 0;
                // read side first so a same-edge fetch sees memory before the write
                if (rfresh) begin
                    e_ar_ready = 1; rfresh = 0;
                end else if (e_ar_ready && ar_valid) begin
                    e_ar_ready = 0; ra = ar_addr; rl = int'(ar_len); rb = 0;
                    e_r_id = ar_id; rfetch = 1;
                end else if (rfetch) begin
                    rfetch = 0; e_r_valid = 1; e_r_last = (rb == rl);
                    if (inr(ra)) begin
                        idx = widx(ra);
                        e_r_data = mm[idx]; e_r_resp = 2'b00;
                        for (int i = 0; i < 8; i++) e_r_mask[8*i +: 8] = {8{mk[idx][i]}};
                    end else begin
                        e_r_data = 64'h0; e_r_resp = 2'b10; e_r_mask = '1;
                    end
                end else if (e_r_valid && r_ready) begin
                    e_r_valid = 0;
                    if (rb == rl) e_ar_ready = 1;
                    else begin rb++; ra = ra + 32'd8; rfetch = 1; end
                end
                if (wfresh) begin
                    e_aw_ready = 1; wfresh = 0;
                end else if (e_aw_ready && aw_valid) begin
                    e_aw_ready = 0; e_w_ready = 1; wa = aw_addr; wl = int'(aw_len);
                    wb = 0; werr = 0; wid = aw_id;
                end else if (e_w_ready && w_valid) begin
                    if (inr(wa)) begin
                        idx = widx(wa);
                        for (int i = 0; i < 8; i++) if (w_strb[i]) begin
                            mm[idx][8*i +: 8] = w_data[8*i +: 8];
                            mk[idx][i] = 1'b1;
                        end
                    end else werr = 1;
                    if (w_last != (wb == wl)) werr = 1;
                    if (wb == wl) begin
                        e_w_ready = 0; e_b_valid = 1; e_b_id = wid;
                        e_b_resp = werr ? 2'b10 : 2'b00;
                    end else begin
                        wb++; wa = wa + 32'd8;
                    end
                end else if (e_b_valid && b_ready) begin
                    e_b_valid = 0; e_aw_ready = 1;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    logic [63:0] wd [256];
    logic [7:0]  ws [256];
    logic [63:0] rd_data [256];
    logic [1:0]  rd_resp [256];
    logic        rd_last [256];
    logic [3:0]  rd_id [256];
    int ar_cyc, first_cyc;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input int len, input logic [3:0] id,
                            input int bad_last, input bit rnd,
                            output logic [1:0] resp, output logic [3:0] bid);
        int n;
        aw_addr = a; aw_len = 8'(len); aw_id = id; aw_valid = 1;
        n = 0;
        while (aw_ready !== 1'b1 && n < TMO) begin step(); n++; end
        if (n >= TMO) tmo("aw_handshake");
        step();
        aw_valid = 0;
        for (int b = 0; b <= len; b++) begin
            if (rnd) repeat ($urandom_range(0, 2)) step();
            w_data = wd[b]; w_strb = ws[b];
            w_last = (bad_last >= 0) ? (b == bad_last) : (b == len);
            w_valid = 1;
            n = 0;
            while (w_ready !== 1'b1 && n < TMO) begin step(); n++; end
            if (n >= TMO) tmo("w_handshake");
            step();
            w_valid = 0;
        end
        n = 0;
        while (b_valid !== 1'b1 && n < TMO) begin step(); n++; end
        if (n >= TMO) tmo("b_valid");
        if (rnd) repeat ($urandom_range(0, 3)) step();
        resp = b_resp; bid = b_id;
        b_ready = 1;
        step();
        b_ready = 0;
    endtask

    task automatic recv_beat(input int b, input int stall);
        int n;
        n = 0;
        while (r_valid !== 1'b1 && n < TMO) begin step(); n++; end
        if (n >= TMO) tmo("r_valid");
        if (b == 0) first_cyc = cyc;
        repeat (stall) step();
        rd_data[b] = r_data; rd_resp[b] = r_resp; rd_last[b] = r_last; rd_id[b] = r_id;
        r_ready = 1;
        step();
        r_ready = 0;
    endtask

    task automatic send_ar(input logic [31:0] a, input int len, input logic [3:0] id);
        int n;
        ar_addr = a; ar_len = 8'(len); ar_id = id; ar_valid = 1;
        n = 0;
        while (ar_ready !== 1'b1 && n < TMO) begin step(); n++; end
        if (n >= TMO) tmo("ar_handshake");
        ar_cyc = cyc;
        step();
        ar_valid = 0;
    endtask

    task automatic do_read(input logic [31:0] a, input int len, input logic [3:0] id,
                           input int stall, input bit rnd);
        send_ar(a, len, id);
        for (int b = 0; b <= len; b++)
            recv_beat(b, rnd ? int'($urandom_range(0, 3)) : stall);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [1:0] rr;
    logic [3:0] ri;
    initial begin
        rst = 0; aw_valid = 0; w_valid = 0; b_ready = 0; ar_valid = 0; r_ready = 0;
        aw_id = 0; aw_addr = 0; aw_len = 0; w_data = 0; w_strb = 0; w_last = 0;
        ar_id = 0; ar_addr = 0; ar_len = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        step();
        chk("aw_ready_after_release", aw_ready, 1);
        chk("ar_ready_after_release", ar_ready, 1);

        // single full-word write then read
        wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
        do_write(BASE, 0, 4'd3, -1, 0, rr, ri);
        chk("t1_b_resp", rr, 2'b00);
        chk("t1_b_id", ri, 4'd3);
        do_read(BASE, 0, 4'd5, 0, 0);
        chk("t1_r_data", rd_data[0], 64'h1122334455667788);
        chk("t1_r_id", rd_id[0], 4'd5);
        chk("t1_r_last", rd_last[0], 1);
        chk("t1_r_latency", 64'(first_cyc - ar_cyc), 64'd2);

        // partial strobe over all-ones
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
        do_write(BASE + 32'd16, 0, 4'd1, -1, 0, rr, ri);
        wd[0] = 64'hAAAA_AAAA_AAAA_AAAA; ws[0] = 8'h0F;
        do_write(BASE + 32'd16, 0, 4'd1, -1, 0, rr, ri);
        do_read(BASE + 32'd16, 0, 4'd2, 0, 0);
        chk("t2_strobe_merge", rd_data[0], 64'hFFFF_FFFF_AAAA_AAAA);

        // 4-beat INCR write, stalled 4-beat read
        for (int b = 0; b < 4; b++) begin wd[b] = 64'(b); ws[b] = 8'hFF; end
        do_write(BASE + 32'd8, 3, 4'd6, -1, 0, rr, ri);
        chk("t3_b_resp", rr, 2'b00);
        do_read(BASE + 32'd8, 3, 4'd9, 2, 0);
        for (int b = 0; b < 4; b++) begin
            chk("t3_burst_data", rd_data[b], 64'(b));
            chk("t3_burst_last", rd_last[b], (b == 3));
        end

        // one past the end of the window
        wd[0] = 64'hDEAD_BEEF_DEAD_BEEF; ws[0] = 8'hFF;
        do_write(BASE + 32'(8 * DEPTH), 0, 4'd4, -1, 0, rr, ri);
        chk("t4_b_resp_oor", rr, 2'b10);
        do_read(BASE + 32'(8 * DEPTH), 0, 4'd4, 0, 0);
        chk("t4_r_resp_oor", rd_resp[0], 2'b10);
        chk("t4_r_data_oor", rd_data[0], 64'h0);
        do_read(BASE, 0, 4'd4, 0, 0);
        chk("t4_word0_intact", rd_data[0], 64'h1122334455667788);

        // early w_last on a 2-beat burst
        wd[0] = 64'h5; wd[1] = 64'h6; ws[0] = 8'hFF; ws[1] = 8'hFF;
        do_write(BASE + 32'd40, 1, 4'd8, 0, 0, rr, ri);
        chk("t5_b_resp_wlast", rr, 2'b10);
        chk("t5_b_id", ri, 4'd8);

        // reset pulse during beat 2 of a 4-beat read
        send_ar(BASE + 32'd8, 3, 4'd7);
        recv_beat(0, 0);
        recv_beat(1, 0);
        begin
            int n;
            n = 0;
            while (r_valid !== 1'b1 && n < TMO) begin step(); n++; end
            if (n >= TMO) tmo("t6_r_valid");
        end
        rst = 0;
        repeat (2) step();
        rst = 1;
        step();
        chk("t6_r_valid_after_rst", r_valid, 0);
        chk("t6_ar_ready_after_rst", ar_ready, 1);
        do_read(BASE + 32'd8, 3, 4'd2, 0, 0);
        chk("t6_read_after_rst", rd_data[2], 64'd2);
        chk("t6_last_after_rst", rd_last[3], 1);

        // 256-beat read running off the end of the window
        do_read(BASE, 255, 4'd10, 0, 0);
        chk("len255_last", rd_last[255], 1);
        chk("len255_resp_in", rd_resp[DEPTH-1], 2'b00);
        chk("len255_resp_out", rd_resp[DEPTH], 2'b10);

        // randomized traffic, sometimes with concurrent read and write
        for (int it = 0; it < 60; it++) begin
            logic [31:0] wa_r, ra_r;
            int wl_r, rl_r, sel;
            wa_r = BASE + 32'(8 * $urandom_range(0, DEPTH + 3)) + 32'($urandom_range(0, 7));
            ra_r = ($urandom_range(0, 3) == 0) ? wa_r
                 : BASE + 32'(8 * $urandom_range(0, DEPTH + 3));
            if ($urandom_range(0, 9) == 0) wa_r = BASE - 32'd8;
            wl_r = $urandom_range(0, 5);
            rl_r = $urandom_range(0, 5);
            for (int b = 0; b <= wl_r; b++) begin
                wd[b] = {$urandom, $urandom};
                ws[b] = 8'($urandom);
            end
            sel = $urandom_range(0, 2);
            if (sel == 0) do_write(wa_r, wl_r, 4'($urandom), -1, 1, rr, ri);
            else if (sel == 1) do_read(ra_r, rl_r, 4'($urandom), 0, 1);
            else begin
                fork
                    do_write(wa_r, wl_r, 4'($urandom), -1, 1, rr, ri);
                    do_read(ra_r, rl_r, 4'($urandom), 0, 1);
                join
            end
        end

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
